// File: rtl/matrix_fetch_ctrl.sv
// rtl/matrix_fetch_ctrl.sv - operand fetch: one AXI burst read per matrix, beats landed into the operand buffer
// axi_out = {request_valid, BASE[31:0], sel[2:0], issend, burst_num[5:0], burst_size[2:0]}
module matrix_fetch_ctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int BUF_AW     = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [1:0]              mat,
    input  logic [3:0]              cfg,
    input  logic [127:0]            base,
    output logic [45:0]             axi_out,
    input  logic [DATA_WIDTH+34:0]  axi_in,
    output logic                    buf_we,
    output logic [BUF_AW-1:0]       buf_addr,
    output logic [DATA_WIDTH-1:0]   buf_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam logic [2:0] BURST_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_mat;
    logic [3:0]            r_cfg;
    logic [31:0]           r_base;
    logic [BUF_AW-1:0]     r_count;
    logic                  r_err;

    logic                  w_finish;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_rvalid;
    logic                  w_arready;
    logic                  w_unused;

    logic [3:0]            w_log_elems;
    logic [3:0]            w_log_width;
    logic [3:0]            w_log_beats;
    logic [5:0]            w_burst_num;
    logic [2:0]            w_sel;
    logic                  w_at_last;

    logic                  w_accept;
    logic                  w_bad_start;
    logic                  w_err_set;
    logic                  w_we;
    logic                  w_req_valid;
    logic                  w_done;

    assign w_finish  = axi_in[DATA_WIDTH+34];
    assign w_rdata   = axi_in[DATA_WIDTH+33:34];
    assign w_rvalid  = axi_in[1];
    assign w_arready = axi_in[0];
    assign w_unused  = ^{base[127:96], axi_in[33:2]};

    // Sizes are powers of two, so beats = 2^(log_elems + log_width - log2(256)).
    always_comb begin
        w_log_elems = 4'd8;
        w_log_width = 4'd5;
        w_sel       = 3'b001;
        case (r_mat)
            2'd0: begin
                w_sel = 3'b100;
                case (r_cfg[3:2])
                    2'd0:    w_log_elems = 4'd9;
                    2'd1:    w_log_elems = 4'd8;
                    default: w_log_elems = 4'd7;
                endcase
            end
            2'd1: begin
                w_sel = 3'b010;
                case (r_cfg[3:2])
                    2'd0:    w_log_elems = 4'd7;
                    2'd1:    w_log_elems = 4'd8;
                    default: w_log_elems = 4'd9;
                endcase
            end
            default: begin
                w_sel       = 3'b001;
                w_log_elems = 4'd8;
            end
        endcase
        // C is the mixed-precision accumulator: always 32-bit elements.
        if (r_mat != 2'd2) begin
            case (r_cfg[1:0])
                2'd0:    w_log_width = 4'd5;
                2'd1:    w_log_width = 4'd4;
                2'd2:    w_log_width = 4'd3;
                default: w_log_width = 4'd2;
            endcase
        end
    end

    assign w_log_beats = w_log_elems + w_log_width - 4'd8;
    assign w_burst_num = 6'((7'd1 << w_log_beats) - 7'd1);
    assign w_at_last   = (r_count == BUF_AW'(w_burst_num));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_bad_start = 1'b0;
        w_err_set   = 1'b0;
        w_we        = 1'b0;
        w_req_valid = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (mat != 2'd3) begin
                        w_accept = 1'b1;
                        w_next   = S_REQ;
                    end else begin
                        w_bad_start = 1'b1;
                    end
                end
            end
            S_REQ: begin
                w_req_valid = 1'b1;
                if (w_arready) begin
                    w_next = S_RECV;
                end
            end
            S_RECV: begin
                if (w_rvalid) begin
                    if (w_finish) begin
                        w_we      = 1'b1;
                        w_err_set = !w_at_last;
                        w_next    = S_DONE;
                    end else if (w_at_last) begin
                        // Overrun: beyond the burst length, drop the beat and wait for finish.
                        w_err_set = 1'b1;
                    end else begin
                        w_we = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mat   <= 2'd0;
            r_cfg   <= 4'd0;
            r_base  <= 32'd0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_mat   <= mat;
            r_cfg   <= cfg;
            r_count <= '0;
            r_err   <= 1'b0;
            case (mat)
                2'd0:    r_base <= base[31:0];
                2'd1:    r_base <= base[63:32];
                default: r_base <= base[95:64];
            endcase
        end else begin
            if (w_bad_start || w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_we) begin
                r_count <= r_count + BUF_AW'(1);
            end
        end
    end

    assign axi_out   = w_req_valid ? {1'b1, r_base, w_sel, 1'b0, w_burst_num, BURST_SIZE} : '0;
    assign buf_we    = w_we;
    assign buf_addr  = r_count;
    assign buf_wdata = w_we ? w_rdata : '0;
    assign busy      = (r_state != S_IDLE);
    assign done      = w_done;
    assign err       = r_err;

endmodule

// File: tb/tb_matrix_fetch_ctrl.sv
// tb/tb_matrix_fetch_ctrl.sv - directed self-checking bench for matrix_fetch_ctrl
module tb_matrix_fetch_ctrl;

    localparam int DW = 256;
    localparam int AW = 6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     mat = 2'd0;
    logic [3:0]     cfg = 4'd0;
    logic [127:0]   base = '0;
    logic [45:0]    axi_out;
    logic [DW+34:0] axi_in;
    logic           buf_we;
    logic [AW-1:0]  buf_addr;
    logic [DW-1:0]  buf_wdata;
    logic           busy;
    logic           done;
    logic           err;

    logic           arready = 1'b0;
    logic           rvalid = 1'b0;
    logic           finish = 1'b0;
    logic [DW-1:0]  rdata = '0;
    logic [31:0]    burst_id = 32'h5a;

    assign axi_in = {finish, rdata, burst_id, rvalid, arready};

    matrix_fetch_ctrl #(.DATA_WIDTH(DW), .BUF_AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mat       (mat),
        .cfg       (cfg),
        .base      (base),
        .axi_out   (axi_out),
        .axi_in    (axi_in),
        .buf_we    (buf_we),
        .buf_addr  (buf_addr),
        .buf_wdata (buf_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic        f_valid;
    logic [31:0] f_base;
    logic [2:0]  f_sel;
    logic        f_issend;
    logic [5:0]  f_len;
    logic [2:0]  f_size;
    assign {f_valid, f_base, f_sel, f_issend, f_len, f_size} = axi_out;

    int n_total = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int            wr_addr[$];
    logic [DW-1:0] wr_data[$];
    int            n_req = 0;
    logic          prev_rv = 1'b0;

    always @(negedge clk) begin
        if (buf_we) begin
            wr_addr.push_back(int'(buf_addr));
            wr_data.push_back(buf_wdata);
        end
        if (f_valid && !prev_rv) n_req++;
        prev_rv = f_valid;
    end

    function automatic logic [DW-1:0] beat(input int t, input int i);
        logic [31:0] w;
        w = 32'(t * 256 + i);
        return {8{w}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic issue(input logic [1:0] m, input logic [3:0] c, input logic [127:0] b);
        start = 1'b1;
        mat   = m;
        cfg   = c;
        base  = b;
        tick();
        start = 1'b0;
    endtask

    task automatic grant(input int delay);
        for (int d = 0; d < delay; d++) tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    task automatic send_beats(input int t, input int n, input bit gap, input int fin_idx);
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                rvalid = 1'b0;
                finish = 1'b0;
                tick();
            end
            rvalid = 1'b1;
            finish = (i == fin_idx);
            rdata  = beat(t, i);
            tick();
        end
        rvalid = 1'b0;
        finish = 1'b0;
    endtask

    task automatic verify(input string tag, input int n, input int t);
        int bad;
        bad = 0;
        check({tag, "_nwr"}, wr_addr.size(), n);
        for (int i = 0; i < wr_addr.size() && i < n; i++) begin
            if (wr_addr[i] != i || wr_data[i] !== beat(t, i)) bad++;
        end
        check({tag, "_order"}, bad, 0);
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_we", buf_we, 0);
        check("rst_addr", buf_addr, 0);
        check("rst_axi", axi_out, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // A M32K16 FP32: 64 beats
        clear_log();
        issue(2'd0, 4'b0000, 128'h0);
        @(negedge clk);
        check("t1_reqv", f_valid, 1);
        check("t1_base", f_base, 32'h0);
        check("t1_sel", f_sel, 3'b100);
        check("t1_issend", f_issend, 0);
        check("t1_len", f_len, 63);
        check("t1_size", f_size, 5);
        check("t1_busy", busy, 1);
        grant(3);
        @(negedge clk);
        check("t1_reqv_drop", f_valid, 0);
        send_beats(1, 64, 1'b0, 63);
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_err", err, 0);
        verify("t1", 64, 1);
        tick();
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        check("t1_idle", busy, 0);

        // B K16N32 INT4: 8 beats with gaps
        clear_log();
        issue(2'd1, 4'b1011, {32'h0, 32'h0, 32'h800, 32'h0});
        @(negedge clk);
        check("t2_base", f_base, 32'h800);
        check("t2_sel", f_sel, 3'b010);
        check("t2_len", f_len, 7);
        grant(0);
        send_beats(2, 8, 1'b1, 7);
        @(negedge clk);
        check("t2_done", done, 1);
        check("t2_err", err, 0);
        verify("t2", 8, 2);
        tick();

        // illegal mat
        issue(2'd3, 4'b0000, 128'h0);
        @(negedge clk);
        check("e1_err", err, 1);
        check("e1_reqv", f_valid, 0);
        check("e1_busy", busy, 0);

        // A M8K16 INT4, premature finish on the first beat
        clear_log();
        issue(2'd0, 4'b1011, 128'h0);
        @(negedge clk);
        check("e2_err_clr", err, 0);
        check("e2_len", f_len, 1);
        grant(0);
        send_beats(3, 1, 1'b0, 0);
        @(negedge clk);
        check("e2_done", done, 1);
        check("e2_err", err, 1);
        verify("e2", 1, 3);
        tick();

        // overrun: third beat after a two-beat burst
        clear_log();
        issue(2'd0, 4'b1011, 128'h0);
        grant(0);
        send_beats(4, 3, 1'b0, 2);
        @(negedge clk);
        check("e3_done", done, 1);
        check("e3_err", err, 1);
        check("e3_nwr", wr_addr.size(), 2);
        if (wr_addr.size() == 2) begin
            check("e3_addr1", wr_addr[1], 1);
            check("e3_data1", wr_data[1], beat(4, 2));
        end
        tick();

        // C with strays in IDLE and REQ
        clear_log();
        rvalid = 1'b1;
        finish = 1'b1;
        rdata  = beat(9, 9);
        @(negedge clk);
        check("t3_stray_idle", buf_we, 0);
        issue(2'd2, 4'b1010, {32'h0, 32'h1000, 32'h0, 32'h0});
        @(negedge clk);
        check("t3_stray_req", buf_we, 0);
        check("t3_err_clr", err, 0);
        tick();
        @(negedge clk);
        check("t3_hold_req", f_valid, 1);
        check("t3_base", f_base, 32'h1000);
        check("t3_sel", f_sel, 3'b001);
        check("t3_len", f_len, 31);
        rvalid = 1'b0;
        finish = 1'b0;
        grant(1);
        send_beats(5, 32, 1'b0, 31);
        @(negedge clk);
        check("t3_done", done, 1);
        verify("t3", 32, 5);
        tick();

        // reset mid-burst
        clear_log();
        issue(2'd2, 4'b0010, {32'h0, 32'h1000, 32'h0, 32'h0});
        grant(0);
        send_beats(6, 10, 1'b0, -1);
        check("r_pre_nwr", wr_addr.size(), 10);
        rvalid = 1'b1;
        rdata  = beat(6, 10);
        rst_n  = 1'b0;
        #1;
        check("r_busy", busy, 0);
        check("r_we", buf_we, 0);
        check("r_wdata", buf_wdata, 0);
        check("r_axi", axi_out, 0);
        check("r_done", done, 0);
        check("r_addr", buf_addr, 0);
        tick();
        rst_n = 1'b1;
        clear_log();
        send_beats(6, 22, 1'b0, 21);
        check("r_post_nwr", wr_addr.size(), 0);
        check("r_post_busy", busy, 0);
        clear_log();
        issue(2'd0, 4'b1011, {96'h0, 32'h40});
        @(negedge clk);
        check("r_new_base", f_base, 32'h40);
        grant(1);
        send_beats(7, 2, 1'b0, 1);
        @(negedge clk);
        check("r_new_done", done, 1);
        check("r_new_err", err, 0);
        verify("r_new", 2, 7);
        tick();

        // start held high across a fetch
        n_req = 0;
        clear_log();
        start = 1'b1;
        mat   = 2'd0;
        cfg   = 4'b1011;
        base  = 128'h0;
        tick();
        grant(0);
        send_beats(8, 2, 1'b0, 1);
        @(negedge clk);
        check("h_done", done, 1);
        tick();
        @(negedge clk);
        check("h_idle", busy, 0);
        check("h_idle_req", f_valid, 0);
        tick();
        @(negedge clk);
        check("h_req2", f_valid, 1);
        start = 1'b0;
        grant(0);
        send_beats(8, 2, 1'b0, 1);
        tick();
        tick();
        check("h_nreq", n_req, 2);
        check("h_nwr", wr_addr.size(), 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
